// File: rtl/cm3_mcu_top_if.sv
// JTAG pin bundle between a debugger (master) and the MCU debug TAP (slave).
// No latency of its own; it is plain wiring.
// No backpressure: JTAG is paced entirely by the debugger's TCK.
interface cm3_mcu_top_if;
  logic TDI;
  logic TCK;
  logic TMS;
  logic TRST;
  logic TDO;

  modport master (output TDI, output TCK, output TMS, output TRST, input TDO);
  modport slave  (input TDI, input TCK, input TMS, input TRST, output TDO);
endinterface

// File: rtl/cm3_mcu_top.sv
// JTAG TAP oversampled by CLK: IDCODE, BYPASS, and word access to a small debug memory.
// Pins reach the TAP 2 CLKs after synchronizing; TDO is registered 1 CLK after the synced TCK fall.
// No backpressure: the TAP follows TCK, which must stay high and low for at least 3 CLKs each.
module cm3_mcu_top #(
  parameter logic [31:0] IDCODE    = 32'h4BA00477,
  parameter int          MEM_DEPTH = 16
) (
  input  logic          CLK,
  input  logic          RST,
  cm3_mcu_top_if.slave  jtag
);

  localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  localparam logic [3:0] S_TLR    = 4'h0;
  localparam logic [3:0] S_RTI    = 4'h1;
  localparam logic [3:0] S_SEL_DR = 4'h2;
  localparam logic [3:0] S_CAP_DR = 4'h3;
  localparam logic [3:0] S_SH_DR  = 4'h4;
  localparam logic [3:0] S_EX1_DR = 4'h5;
  localparam logic [3:0] S_PAU_DR = 4'h6;
  localparam logic [3:0] S_EX2_DR = 4'h7;
  localparam logic [3:0] S_UPD_DR = 4'h8;
  localparam logic [3:0] S_SEL_IR = 4'h9;
  localparam logic [3:0] S_CAP_IR = 4'hA;
  localparam logic [3:0] S_SH_IR  = 4'hB;
  localparam logic [3:0] S_EX1_IR = 4'hC;
  localparam logic [3:0] S_PAU_IR = 4'hD;
  localparam logic [3:0] S_EX2_IR = 4'hE;
  localparam logic [3:0] S_UPD_IR = 4'hF;

  localparam logic [3:0] IR_IDCODE = 4'h1;
  localparam logic [3:0] IR_ADDR   = 4'h2;
  localparam logic [3:0] IR_DATA   = 4'h3;

  logic          r_tck_s1, r_tck_s2, r_tck_prev;
  logic          r_tms_s1, r_tms_s2;
  logic          r_tdi_s1, r_tdi_s2;
  logic          r_trst_s1, r_trst_s2;
  logic [3:0]    r_state;
  logic [3:0]    r_ir;
  logic [3:0]    r_ir_sh;
  logic [31:0]   r_dr_sh;
  logic [AW-1:0] r_addr;
  logic          r_tdo;
  logic [31:0]   r_mem [MEM_DEPTH];

  logic          w_tck_rise;
  logic          w_tck_fall;
  logic [3:0]    w_next;
  logic          w_mem_we;

  // Edges are only recognised on clean 0/1 levels, so X on the pins never advances the TAP.
  assign w_tck_rise = (r_tck_s2 == 1'b1) && (r_tck_prev == 1'b0);
  assign w_tck_fall = (r_tck_s2 == 1'b0) && (r_tck_prev == 1'b1);
  assign w_mem_we   = r_trst_s2 && w_tck_rise && (r_state == S_UPD_DR) && (r_ir == IR_DATA);
  assign jtag.TDO   = r_tdo;

  // Two-flop synchronizers for every pin plus a third TCK flop for edge detection.
  always_ff @(posedge CLK) begin
    if (RST) begin
      {r_tck_s1, r_tck_s2, r_tck_prev} <= 3'b000;
      {r_tms_s1, r_tms_s2}             <= 2'b00;
      {r_tdi_s1, r_tdi_s2}             <= 2'b00;
      {r_trst_s1, r_trst_s2}           <= 2'b00;
    end else begin
      r_tck_s1   <= jtag.TCK;
      r_tck_s2   <= r_tck_s1;
      r_tck_prev <= r_tck_s2;
      r_tms_s1   <= jtag.TMS;
      r_tms_s2   <= r_tms_s1;
      r_tdi_s1   <= jtag.TDI;
      r_tdi_s2   <= r_tdi_s1;
      r_trst_s1  <= jtag.TRST;
      r_trst_s2  <= r_trst_s1;
    end
  end

  // Standard 1149.1 state transitions, selected by the synced TMS.
  always_comb begin
    w_next = S_TLR;
    case (r_state)
      S_TLR:    w_next = r_tms_s2 ? S_TLR    : S_RTI;
      S_RTI:    w_next = r_tms_s2 ? S_SEL_DR : S_RTI;
      S_SEL_DR: w_next = r_tms_s2 ? S_SEL_IR : S_CAP_DR;
      S_CAP_DR: w_next = r_tms_s2 ? S_EX1_DR : S_SH_DR;
      S_SH_DR:  w_next = r_tms_s2 ? S_EX1_DR : S_SH_DR;
      S_EX1_DR: w_next = r_tms_s2 ? S_UPD_DR : S_PAU_DR;
      S_PAU_DR: w_next = r_tms_s2 ? S_EX2_DR : S_PAU_DR;
      S_EX2_DR: w_next = r_tms_s2 ? S_UPD_DR : S_SH_DR;
      S_UPD_DR: w_next = r_tms_s2 ? S_SEL_DR : S_RTI;
      S_SEL_IR: w_next = r_tms_s2 ? S_TLR    : S_CAP_IR;
      S_CAP_IR: w_next = r_tms_s2 ? S_EX1_IR : S_SH_IR;
      S_SH_IR:  w_next = r_tms_s2 ? S_EX1_IR : S_SH_IR;
      S_EX1_IR: w_next = r_tms_s2 ? S_UPD_IR : S_PAU_IR;
      S_PAU_IR: w_next = r_tms_s2 ? S_EX2_IR : S_PAU_IR;
      S_EX2_IR: w_next = r_tms_s2 ? S_UPD_IR : S_SH_IR;
      S_UPD_IR: w_next = r_tms_s2 ? S_SEL_DR : S_RTI;
      default:  w_next = S_TLR;
    endcase
  end

  // TAP state, IR/DR capture-shift-update on TCK rise, TDO on TCK fall; TRST beats any edge.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_TLR;
      r_ir    <= IR_IDCODE;
      r_ir_sh <= 4'h0;
      r_dr_sh <= 32'h0;
      r_addr  <= '0;
      r_tdo   <= 1'b0;
    end else if (!r_trst_s2) begin
      r_state <= S_TLR;
      r_ir    <= IR_IDCODE;
      r_tdo   <= 1'b0;
    end else if (w_tck_rise) begin
      r_state <= w_next;
      case (r_state)
        S_CAP_IR: r_ir_sh <= 4'b0001;
        S_SH_IR:  r_ir_sh <= {r_tdi_s2, r_ir_sh[3:1]};
        S_UPD_IR: r_ir    <= r_ir_sh;
        S_CAP_DR: begin
          case (r_ir)
            IR_IDCODE: r_dr_sh <= IDCODE;
            IR_ADDR:   r_dr_sh <= {24'h0, {(8 - AW){1'b0}}, r_addr};
            IR_DATA:   r_dr_sh <= r_mem[r_addr];
            default:   r_dr_sh <= 32'h0;
          endcase
        end
        S_SH_DR: begin
          case (r_ir)
            IR_IDCODE, IR_DATA: r_dr_sh <= {r_tdi_s2, r_dr_sh[31:1]};
            IR_ADDR:            r_dr_sh <= {24'h0, r_tdi_s2, r_dr_sh[7:1]};
            default:            r_dr_sh <= {31'h0, r_tdi_s2};
          endcase
        end
        S_UPD_DR: begin
          if (r_ir == IR_ADDR) begin
            r_addr <= r_dr_sh[AW-1:0];
          end else if (r_ir == IR_DATA) begin
            r_addr <= r_addr + 1'b1;
          end
        end
        default: ;
      endcase
      // Any path into Test-Logic-Reset reselects IDCODE.
      if (w_next == S_TLR) begin
        r_ir <= IR_IDCODE;
      end
    end else if (w_tck_fall) begin
      if (r_state == S_SH_IR) begin
        r_tdo <= r_ir_sh[0];
      end else if (r_state == S_SH_DR) begin
        r_tdo <= r_dr_sh[0];
      end else begin
        r_tdo <= 1'b0;
      end
    end
  end

  // Debug memory: cleared by RST, written back from the DATA register on Update-DR.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < MEM_DEPTH; i++) begin
        r_mem[i] <= 32'h0;
      end
    end else if (w_mem_we) begin
      r_mem[r_addr] <= r_dr_sh;
    end
  end

endmodule

// File: tb/tb_cm3_mcu_top.sv
// Bench for cm3_mcu_top: drives JTAG scans and compares TDO streams to a scan-level model.
// Expected scan output = captured value followed by the shifted-in bits; update = final window.
// All waits are fixed CLK counts, so the run always terminates.
module tb_cm3_mcu_top;

  localparam logic [31:0] IDC = 32'h4BA00477;

  logic CLK = 1'b0;
  logic RST;
  cm3_mcu_top_if jtag_if ();

  cm3_mcu_top dut (
    .CLK  (CLK),
    .RST  (RST),
    .jtag (jtag_if)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_err    = 0;

  // Scan-level reference state.
  logic [3:0]  m_ir;
  int          m_addr;
  logic [31:0] m_mem [16];

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int dr_len(input logic [3:0] ir);
    case (ir)
      4'h1, 4'h3: return 32;
      4'h2:       return 8;
      default:    return 1;
    endcase
  endfunction

  function automatic logic [63:0] cap_val(input logic [3:0] ir);
    case (ir)
      4'h1:    return {32'h0, IDC};
      4'h2:    return 64'(m_addr);
      4'h3:    return {32'h0, m_mem[m_addr]};
      default: return 64'h0;
    endcase
  endfunction

  // One TCK period with random high/low phase lengths; returns TDO late in the low phase.
  task automatic tck(input logic tms, input logic tdi, output logic tdo);
    jtag_if.TMS = tms;
    jtag_if.TDI = tdi;
    @(negedge CLK);
    jtag_if.TCK = 1'b1;
    repeat ($urandom_range(6, 3)) @(negedge CLK);
    jtag_if.TCK = 1'b0;
    repeat ($urandom_range(6, 3)) @(negedge CLK);
    tdo = jtag_if.TDO;
  endtask

  task automatic tck0(input logic tms);
    logic b;
    tck(tms, 1'b0, b);
  endtask

  task automatic model_reset();
    m_ir   = 4'h1;
    m_addr = 0;
    for (int i = 0; i < 16; i++) m_mem[i] = 32'h0;
  endtask

  task automatic do_reset();
    jtag_if.TCK  = 1'b0;
    jtag_if.TMS  = 1'b1;
    jtag_if.TRST = 1'b1;
    jtag_if.TDI  = 1'b0;
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    model_reset();
    repeat (3) @(negedge CLK);
  endtask

  // From Run-Test/Idle: full IR scan back to Run-Test/Idle.
  task automatic scan_ir(input logic [3:0] v, input string tag);
    logic [3:0] got;
    logic b;
    got = 4'h0;
    tck0(1'b1);
    tck0(1'b1);
    tck0(1'b0);
    tck(1'b0, 1'b0, b);
    got[0] = b;
    for (int i = 0; i < 4; i++) begin
      tck(i == 3, v[i], b);
      if (i < 3) got[i+1] = b;
    end
    check_val(tag, 64'(got), 64'h1);
    tck0(1'b1);
    tck0(1'b0);
    m_ir = v;
  endtask

  // From Run-Test/Idle: DR scan of n bits (n may be 0) back to Run-Test/Idle.
  task automatic scan_dr(input int n, input logic [63:0] d, input string tag);
    int           len;
    logic [127:0] combo;
    logic [63:0]  got, exp, mask;
    logic [31:0]  fin;
    logic         b;
    len   = dr_len(m_ir);
    combo = ({64'h0, d} << len) | {64'h0, cap_val(m_ir)};
    mask  = (64'h1 << n) - 64'h1;
    exp   = combo[63:0] & mask;
    got   = 64'h0;
    tck0(1'b1);
    tck0(1'b0);
    if (n == 0) begin
      tck0(1'b1);
    end else begin
      tck(1'b0, 1'b0, b);
      got[0] = b;
      for (int i = 0; i < n; i++) begin
        tck(i == n - 1, d[i], b);
        if (i < n - 1) got[i+1] = b;
      end
      check_val(tag, got, exp);
    end
    tck0(1'b1);
    tck0(1'b0);
    fin = 32'(combo >> n);
    if (len < 32) fin = fin & ((32'h1 << len) - 32'h1);
    if (m_ir == 4'h2) begin
      m_addr = int'(fin[3:0]);
    end else if (m_ir == 4'h3) begin
      m_mem[m_addr] = fin;
      m_addr = (m_addr + 1) % 16;
    end
  endtask

  initial begin
    logic        b;
    logic [3:0]  irv;
    int          op, n;
    logic [63:0] d;

    // Reset with idle pins.
    do_reset();
    check_val("rst_tdo", 64'(jtag_if.TDO), 64'h0);
    tck0(1'b0);
    scan_dr(32, 64'h0, "idcode");
    scan_ir(4'hF, "cap_ir");

    // BYPASS: one-TCK delay of the TDI pattern 1,0,1,1.
    scan_dr(4, 64'hD, "bypass");

    // Memory write then readback at word 5.
    scan_ir(4'h2, "ir_addr");
    scan_dr(8, 64'h05, "addr_wr");
    scan_ir(4'h3, "ir_data");
    scan_dr(32, 64'hDEADBEEF, "data_wr");
    scan_ir(4'h2, "ir_addr2");
    scan_dr(8, 64'h05, "addr_after_wr");
    scan_ir(4'h3, "ir_data2");
    scan_dr(32, 64'hDEADBEEF, "data_rd");
    scan_ir(4'h2, "ir_addr3");
    scan_dr(8, 64'h06, "addr_after_rd");

    // TRST low in the middle of Shift-DR.
    tck0(1'b1);
    tck0(1'b0);
    tck(1'b0, 1'b0, b);
    jtag_if.TRST = 1'b0;
    repeat (4) @(negedge CLK);
    jtag_if.TRST = 1'b1;
    m_ir = 4'h1;
    repeat (3) @(negedge CLK);
    check_val("trst_tdo", 64'(jtag_if.TDO), 64'h0);
    tck0(1'b0);
    scan_dr(32, 64'h0, "trst_idcode");
    scan_ir(4'h2, "ir_addr4");
    scan_dr(8, 64'h05, "addr_set5");
    scan_ir(4'h3, "ir_data3");
    scan_dr(32, 64'hDEADBEEF, "mem5_kept");
    scan_dr(0, 64'h0, "data_zero_shift");
    scan_ir(4'h2, "ir_addr5");
    scan_dr(8, 64'h07, "addr_after_zero");

    // Pause-DR, then five TMS=1 clocks reach Test-Logic-Reset.
    scan_ir(4'hF, "ir_bypass2");
    tck0(1'b1);
    tck0(1'b0);
    tck(1'b0, 1'b0, b);
    tck(1'b1, 1'b1, b);
    tck(1'b0, 1'b0, b);
    check_val("pause_tdo", 64'(b), 64'h0);
    repeat (5) tck0(1'b1);
    m_ir = 4'h1;
    tck0(1'b0);
    scan_dr(32, 64'h0, "pause_tlr_idcode");

    // RST mid-shift: TDO goes to 0 on the next CLK edge.
    tck0(1'b1);
    tck0(1'b0);
    tck(1'b0, 1'b0, b);
    check_val("pre_rst_tdo", 64'(b), 64'h1);
    RST = 1'b1;
    @(posedge CLK);
    #1;
    check_val("rst_mid_tdo", 64'(jtag_if.TDO), 64'h0);
    @(negedge CLK);
    @(negedge CLK);
    jtag_if.TCK = 1'b0;
    RST = 1'b0;
    model_reset();
    repeat (3) @(negedge CLK);
    tck0(1'b0);
    scan_ir(4'h3, "ir_data_post_rst");
    scan_dr(32, 64'h12345678, "mem_cleared");

    // Randomized scans against the model.
    for (int k = 0; k < 40; k++) begin
      op = $urandom_range(0, 9);
      if (op <= 3) begin
        case ($urandom_range(0, 4))
          0: irv = 4'h1;
          1: irv = 4'h2;
          2: irv = 4'h3;
          3: irv = 4'hF;
          default: irv = 4'($urandom);
        endcase
        scan_ir(irv, "rnd_ir");
      end else if (op <= 7) begin
        d = {$urandom, $urandom};
        n = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 40) : dr_len(m_ir);
        scan_dr(n, d, "rnd_dr");
      end else if (op == 8) begin
        jtag_if.TRST = 1'b0;
        repeat ($urandom_range(5, 2)) @(negedge CLK);
        jtag_if.TRST = 1'b1;
        m_ir = 4'h1;
        repeat (3) @(negedge CLK);
        check_val("rnd_trst_tdo", 64'(jtag_if.TDO), 64'h0);
        tck0(1'b0);
      end else begin
        repeat ($urandom_range(7, 5)) tck0(1'b1);
        m_ir = 4'h1;
        tck0(1'b0);
      end
    end
    scan_ir(4'h1, "final_ir");
    scan_dr(32, 64'h0, "final_idcode");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
